// File: rtl/dual_gate_tester.sv
// Exhaustive tester for a dual 4-input gate package: walks all 256 pin vectors,
// waits a settle time, then checks both gate outputs against the ideal function.
module dual_gate_tester #(
  parameter int unsigned GATE_FN       = 0,  // 0=NAND, 1=AND, 2=NOR, 3=OR
  parameter int unsigned SETTLE_CYCLES = 2   // 0..15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       p1a,
  output logic       p1b,
  output logic       p1c,
  output logic       p1d,
  output logic       p2a,
  output logic       p2b,
  output logic       p2c,
  output logic       p2d,
  input  logic       p1y,
  input  logic       p2y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [9:0] err_count,
  output logic [7:0] first_fail_vec
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StDrive  = 3'd1;
  localparam logic [2:0] StSettle = 3'd2;
  localparam logic [2:0] StCheck  = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;

  localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES);

  function automatic logic gate_fn(input logic [3:0] x);
    case (GATE_FN)
      0:       return ~&x;
      1:       return &x;
      2:       return ~|x;
      default: return |x;
    endcase
  endfunction

  logic [2:0] state_q, state_d;
  logic [7:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] pins_q, pins_d;
  logic [9:0] err_q, err_d;
  logic [7:0] ffv_q, ffv_d;
  logic       seen_q, seen_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;

  logic exp1, exp2;
  logic mis1, mis2;

  assign exp1 = gate_fn(vec_q[3:0]);
  assign exp2 = gate_fn(vec_q[7:4]);
  // Case inequality so X/Z from the device is counted as a mismatch.
  assign mis1 = (p1y !== exp1);
  assign mis2 = (p2y !== exp2);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    pins_d  = pins_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    seen_d  = seen_q;
    case (state_q)
      StIdle, StDone: begin
        pins_d = '0;
        if (start) begin
          state_d = StDrive;
          vec_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          ffv_d   = '0;
          seen_d  = 1'b0;
        end
      end
      StDrive: begin
        pins_d  = vec_q;
        cnt_d   = SettleLoad;
        state_d = (SettleLoad == 4'd0) ? StCheck : StSettle;
      end
      StSettle: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        err_d = err_q + {9'd0, mis1} + {9'd0, mis2};
        if ((mis1 || mis2) && !seen_q) begin
          seen_d = 1'b1;
          ffv_d  = vec_q;
        end
        if (vec_q == 8'hFF) begin
          state_d = StDone;
          pins_d  = '0;
        end else begin
          vec_d   = vec_q + 8'd1;
          state_d = StDrive;
        end
      end
      default: begin
        state_d = StIdle;
        pins_d  = '0;
      end
    endcase
  end

  // Result flags trail DONE entry by one clock so they publish the frozen count;
  // a restart from DONE drops them on the same edge that leaves DONE.
  always_comb begin
    done_d = (state_q == StDone) && !start;
    pass_d = done_d && (err_q == 10'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      vec_q   <= '0;
      cnt_q   <= '0;
      pins_q  <= '0;
      err_q   <= '0;
      ffv_q   <= '0;
      seen_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      pins_q  <= pins_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      seen_q  <= seen_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign {p2d, p2c, p2b, p2a, p1d, p1c, p1b, p1a} = pins_q;

  assign busy           = (state_q == StDrive) || (state_q == StSettle) || (state_q == StCheck);
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_vec = ffv_q;

endmodule

// File: tb/tb_dual_gate_tester.sv
// Directed bench: NAND instance with selectable faults, OR instance with zero settle.
module tb_dual_gate_tester;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start0, start1;
  logic [1:0] mode0;
  logic       mode1;

  wire  [7:0] pins0, pins1;
  logic [1:0] y0, y1;
  logic       busy0, done0, pass0, busy1, done1, pass1;
  logic [9:0] err0, err1;
  logic [7:0] ffv0, ffv1;

  int tests = 0;
  int fails = 0;

  dual_gate_tester dut0 (
    .clk(clk), .rst(rst), .start(start0),
    .p1a(pins0[0]), .p1b(pins0[1]), .p1c(pins0[2]), .p1d(pins0[3]),
    .p2a(pins0[4]), .p2b(pins0[5]), .p2c(pins0[6]), .p2d(pins0[7]),
    .p1y(y0[0]), .p2y(y0[1]),
    .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .first_fail_vec(ffv0)
  );

  dual_gate_tester #(.GATE_FN(3), .SETTLE_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .p1a(pins1[0]), .p1b(pins1[1]), .p1c(pins1[2]), .p1d(pins1[3]),
    .p2a(pins1[4]), .p2b(pins1[5]), .p2c(pins1[6]), .p2d(pins1[7]),
    .p1y(y1[0]), .p2y(y1[1]),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail_vec(ffv1)
  );

  // NAND device model: 0 ideal, 1 p1y stuck-at-0, 2 p2y inverted, 3 p1y wrong at 0xA7
  always_comb begin
    y0[0] = ~&pins0[3:0];
    y0[1] = ~&pins0[7:4];
    case (mode0)
      2'd1: y0[0] = 1'b0;
      2'd2: y0[1] = &pins0[7:4];
      2'd3: if (pins0 == 8'hA7) y0[0] = &pins0[3:0];
      default: ;
    endcase
  end

  // OR device model: mode1 forces p2y stuck-at-0
  always_comb begin
    y1[0] = |pins1[3:0];
    y1[1] = mode1 ? 1'b0 : |pins1[7:4];
  end

  task automatic run0(output int cyc);
    @(negedge clk) start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    cyc = 0;
    while (!done0 && cyc < 4000) begin
      @(posedge clk);
      #1 cyc++;
    end
  endtask

  task automatic run1(output int cyc);
    @(negedge clk) start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    cyc = 0;
    while (!done1 && cyc < 4000) begin
      @(posedge clk);
      #1 cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; mode0 = 2'd0; mode1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({busy0, done0, pass0} !== 3'b000 || pins0 !== 8'h00 || err0 !== 10'd0 || ffv0 !== 8'h00) begin
      fails++;
      $display("FAIL reset_dut0: busy/done/pass=%b pins=%h err=%0d ffv=%h, required 000/00/0/00",
               {busy0, done0, pass0}, pins0, err0, ffv0);
    end
    tests++;
    if ({busy1, done1, pass1} !== 3'b000 || pins1 !== 8'h00 || err1 !== 10'd0 || ffv1 !== 8'h00) begin
      fails++;
      $display("FAIL reset_dut1: busy/done/pass=%b pins=%h err=%0d ffv=%h, required 000/00/0/00",
               {busy1, done1, pass1}, pins1, err1, ffv1);
    end
    rst = 1'b0;
  endtask

  task automatic test_nand_ideal;
    int         cyc;
    int         steps;
    logic [7:0] prev;
    mode0 = 2'd0;
    @(negedge clk) start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    cyc = 0; steps = 0; prev = pins0;
    while (!done0 && cyc < 4000) begin
      @(posedge clk);
      #1 cyc++;
      if (cyc == 1) begin
        tests++;
        if (busy0 !== 1'b1) begin
          fails++;
          $display("FAIL ideal_busy: busy=%b, required 1", busy0);
        end
      end
      if (busy0 && pins0 !== prev) begin
        tests++;
        if (pins0 !== prev + 8'd1) begin
          fails++;
          $display("FAIL ideal_walk: pins=%h, required %h", pins0, prev + 8'd1);
        end
        prev = pins0;
        steps++;
      end
    end
    tests++;
    if (cyc != 1025) begin
      fails++;
      $display("FAIL ideal_latency: done after %0d clks, required 1025", cyc);
    end
    tests++;
    if (steps != 255 || prev !== 8'hFF) begin
      fails++;
      $display("FAIL ideal_walk_len: %0d steps ending %h, required 255 ending ff", steps, prev);
    end
    tests++;
    if (pass0 !== 1'b1 || err0 !== 10'd0 || ffv0 !== 8'h00) begin
      fails++;
      $display("FAIL ideal_result: pass=%b err=%0d ffv=%h, required 1/0/00", pass0, err0, ffv0);
    end
    tests++;
    if (pins0 !== 8'h00 || busy0 !== 1'b0) begin
      fails++;
      $display("FAIL ideal_idle_pins: pins=%h busy=%b, required 00/0", pins0, busy0);
    end
  endtask

  task automatic test_stuck_p1y;
    int cyc;
    mode0 = 2'd1;
    run0(cyc);
    tests++;
    if (cyc != 1025 || err0 !== 10'd240 || ffv0 !== 8'h00 || pass0 !== 1'b0) begin
      fails++;
      $display("FAIL stuck_p1y: clks=%0d err=%0d ffv=%h pass=%b, required 1025/240/00/0",
               cyc, err0, ffv0, pass0);
    end
  endtask

  task automatic test_invert_p2y;
    int cyc;
    mode0 = 2'd2;
    run0(cyc);
    tests++;
    if (cyc != 1025 || err0 !== 10'd256 || ffv0 !== 8'h00 || pass0 !== 1'b0) begin
      fails++;
      $display("FAIL invert_p2y: clks=%0d err=%0d ffv=%h pass=%b, required 1025/256/00/0",
               cyc, err0, ffv0, pass0);
    end
  endtask

  task automatic test_single_fault;
    int cyc;
    mode0 = 2'd3;
    run0(cyc);
    tests++;
    if (cyc != 1025 || err0 !== 10'd1 || ffv0 !== 8'hA7 || pass0 !== 1'b0) begin
      fails++;
      $display("FAIL single_fault: clks=%0d err=%0d ffv=%h pass=%b, required 1025/1/a7/0",
               cyc, err0, ffv0, pass0);
    end
  endtask

  task automatic test_start_ignored_and_reset;
    int cyc;
    mode0 = 2'd0;
    @(negedge clk) start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    cyc = 0;
    while (!done0 && cyc < 4000) begin
      @(posedge clk);
      #1 cyc++;
      start0 = (cyc == 300);
    end
    start0 = 1'b0;
    tests++;
    if (cyc != 1025 || pass0 !== 1'b1 || err0 !== 10'd0 || ffv0 !== 8'h00) begin
      fails++;
      $display("FAIL start_ignored: clks=%0d pass=%b err=%0d ffv=%h, required 1025/1/0/00",
               cyc, pass0, err0, ffv0);
    end

    @(negedge clk) start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    repeat (500) @(posedge clk);
    #1;
    tests++;
    if (busy0 !== 1'b1 || pins0 === 8'h00) begin
      fails++;
      $display("FAIL midrun_active: busy=%b pins=%h, required busy 1 with pins nonzero",
               busy0, pins0);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (pins0 !== 8'h00 || busy0 !== 1'b0 || done0 !== 1'b0 || err0 !== 10'd0) begin
      fails++;
      $display("FAIL midrun_reset: pins=%h busy=%b done=%b err=%0d, required 00/0/0/0",
               pins0, busy0, done0, err0);
    end
    @(negedge clk) rst = 1'b0;
    repeat (1100) @(posedge clk);
    #1;
    tests++;
    if (done0 !== 1'b0 || busy0 !== 1'b0 || pass0 !== 1'b0) begin
      fails++;
      $display("FAIL reset_no_resume: done=%b busy=%b pass=%b, required 0/0/0",
               done0, busy0, pass0);
    end
  endtask

  task automatic test_or_fault;
    int cyc;
    mode1 = 1'b1;
    run1(cyc);
    tests++;
    if (cyc != 513 || err1 !== 10'd240 || ffv1 !== 8'h10 || pass1 !== 1'b0) begin
      fails++;
      $display("FAIL or_stuck_p2y: clks=%0d err=%0d ffv=%h pass=%b, required 513/240/10/0",
               cyc, err1, ffv1, pass1);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    mode1 = 1'b0;
    for (int r = 0; r < 2; r++) begin
      run1(cyc);
      tests++;
      if (cyc != 513 || err1 !== 10'd0 || ffv1 !== 8'h00 || pass1 !== 1'b1) begin
        fails++;
        $display("FAIL or_rerun_%0d: clks=%0d err=%0d ffv=%h pass=%b, required 513/0/00/1",
                 r, cyc, err1, ffv1, pass1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nand_ideal();
    test_stuck_p1y();
    test_invert_p2y();
    test_single_fault();
    test_start_ignored_and_reset();
    test_or_fault();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
